// File: rtl/vector_reduce_accumulator.sv
// vector_reduce_accumulator
// Accepts packed vectors of unsigned products and adds their elements into a
// running accumulator, one element per cycle. Chunks are summed until one
// arrives flagged as last. The finished dot product is then held on the output
// until the consumer accepts it.
//
// Build option: define VREDUCE_SAT_EN to clamp the accumulator at its maximum
// value and raise a sticky out_overflow. Without it the accumulator wraps and
// out_overflow is tied low.
module vector_reduce_accumulator #(
  parameter int unsigned VECTOR_SIZE = 8,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ACC_WIDTH   = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] in_vector,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ACC_WIDTH-1:0]              out_sum,
  output logic [7:0]                        out_chunks,
  output logic                              out_overflow,
  output logic                              busy
);

  localparam int unsigned IdxW = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(VECTOR_SIZE - 1);

  typedef enum logic [1:0] {
    StIdle,
    StReduce,
    StOutput
  } state_e;

  state_e                            state_q, state_d;
  logic [DATA_WIDTH*VECTOR_SIZE-1:0] vec_q, vec_d;
  logic                              last_q, last_d;
  logic [IdxW-1:0]                   idx_q, idx_d;
  logic [ACC_WIDTH-1:0]              acc_q, acc_d;
  logic [7:0]                        chunks_q, chunks_d;

  logic [DATA_WIDTH-1:0]             elem;
  logic [ACC_WIDTH-1:0]              elem_ext;
  logic [ACC_WIDTH-1:0]              acc_add;

  // Select the element addressed by the reduction index from the latched vector.
  always_comb begin
    elem = '0;
    for (int unsigned i = 0; i < VECTOR_SIZE; i++) begin
      if (idx_q == IdxW'(i)) begin
        elem = vec_q[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
    elem_ext = ACC_WIDTH'(elem);
  end

`ifdef VREDUCE_SAT_EN
  logic [ACC_WIDTH:0] sum_ext;
  logic               sat_hit;
  logic               ovf_q, ovf_d;

  // Saturating adder: the extra carry bit flags an add that overflowed.
  always_comb begin
    sum_ext = {1'b0, acc_q} + {1'b0, elem_ext};
    sat_hit = sum_ext[ACC_WIDTH];
    acc_add = sat_hit ? {ACC_WIDTH{1'b1}} : sum_ext[ACC_WIDTH-1:0];
  end

  // Sticky overflow: set by any clamped add, cleared only when the sum is taken.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == StReduce && sat_hit) begin
      ovf_d = 1'b1;
    end else if (state_q == StOutput && out_ready) begin
      ovf_d = 1'b0;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign out_overflow = ovf_q;
`else
  // Wrapping adder: the carry out is simply discarded.
  always_comb begin
    acc_add = acc_q + elem_ext;
  end

  assign out_overflow = 1'b0;
`endif

  // Next-state and handshake logic for the IDLE/REDUCE/OUTPUT sequence.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    last_d    = last_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    chunks_d  = chunks_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          vec_d    = in_vector;
          last_d   = in_last;
          idx_d    = '0;
          chunks_d = (chunks_q == 8'hFF) ? chunks_q : chunks_q + 8'd1;
          state_d  = StReduce;
        end
      end

      StReduce: begin
        acc_d = acc_add;
        if (idx_q == IdxLast) begin
          idx_d = '0;
          // A non-final chunk leaves the partial sum in place for the next one.
          state_d = last_q ? StOutput : StIdle;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      StOutput: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_d    = '0;
          chunks_d = '0;
          state_d  = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      vec_q    <= '0;
      last_q   <= 1'b0;
      idx_q    <= '0;
      acc_q    <= '0;
      chunks_q <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      chunks_q <= chunks_d;
    end
  end

  assign out_sum    = acc_q;
  assign out_chunks = chunks_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_vector_reduce_accumulator.sv
// Scoreboard bench for vector_reduce_accumulator. It uses a 20-bit accumulator,
// so random long dot products exercise both the saturating and the wrapping builds.
module tb_vector_reduce_accumulator;

  localparam int unsigned VS = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 20;
  localparam longint unsigned AccMax = (64'd1 << AW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DW*VS-1:0]  in_vector;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [AW-1:0]     out_sum;
  logic [7:0]        out_chunks;
  logic              out_overflow;
  logic              busy;

  vector_reduce_accumulator #(
    .VECTOR_SIZE(VS),
    .DATA_WIDTH (DW),
    .ACC_WIDTH  (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_vector   (in_vector),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_chunks  (out_chunks),
    .out_overflow(out_overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint unsigned sum;
    longint unsigned chunks;
    bit              ovf;
    longint          due;
    int              hold;
  } exp_t;

  exp_t            exp_q[$];
  int unsigned     n_vec = 0;
  int unsigned     n_chk = 0;
  int unsigned     miscompares = 0;
  longint unsigned m_total = 0;
  longint unsigned m_count = 0;
  bit              mon_have = 0;

  // Reference: the exact integer total, viewed through the accumulator's overflow rule.
  function automatic longint unsigned acc_view(input longint unsigned t);
`ifdef VREDUCE_SAT_EN
    return (t > AccMax) ? AccMax : t;
`else
    return t & AccMax;
`endif
  endfunction

  function automatic bit ovf_view(input longint unsigned t);
`ifdef VREDUCE_SAT_EN
    return t > AccMax;
`else
    return 1'b0;
`endif
  endfunction

  function automatic longint unsigned sat255(input longint unsigned n);
    return (n > 255) ? 255 : n;
  endfunction

  function automatic longint unsigned vec_sum(input logic [DW*VS-1:0] v);
    longint unsigned s = 0;
    for (int i = 0; i < VS; i++) s += v[i*DW +: DW];
    return s;
  endfunction

  function automatic logic [DW*VS-1:0] fill(input int unsigned e);
    logic [DW*VS-1:0] v;
    for (int i = 0; i < VS; i++) v[i*DW +: DW] = DW'(e);
    return v;
  endfunction

  function automatic logic [DW*VS-1:0] rand_vec();
    logic [DW*VS-1:0] v;
    for (int i = 0; i < VS; i++) begin
      v[i*DW +: DW] = ($urandom_range(0, 1) == 1) ? DW'(16'hFFFF - $urandom_range(0, 600))
                                                  : DW'($urandom);
    end
    return v;
  endfunction

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned req);
    n_chk++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Issue one chunk; optionally keep in_valid high with junk data, or pulse reset
  // at REDUCE cycle rst_at (0-based).
  task automatic send(input logic [DW*VS-1:0] v, input bit last, input bit junk,
                      input int rst_at, input int hold);
    int waited = 0;
    longint t;
    @(negedge clk);
    in_valid  = 1'b1;
    in_vector = v;
    in_last   = last;
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    t = cyc + 1;
    n_vec++;
    m_total += vec_sum(v);
    m_count++;
    if (last) begin
      exp_q.push_back('{acc_view(m_total), sat255(m_count), ovf_view(m_total), t + VS, hold});
      m_total = 0;
      m_count = 0;
    end
    @(negedge clk);
    in_vector = rand_vec();
    in_last   = ($urandom_range(0, 1) == 1);
    if (!junk) in_valid = 1'b0;
    for (int k = 0; k < VS; k++) begin
      check("in_ready_reduce", in_ready, 0);
      check("busy_reduce", busy, 1);
      check("out_valid_reduce", out_valid, 0);
      if (k == rst_at) begin
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_sum", out_sum, 0);
        check("rst_chunks", out_chunks, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        m_total = 0;
        m_count = 0;
        if (last) void'(exp_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        return;
      end
      if (k == VS - 1) in_valid = 1'b0;
      in_vector = rand_vec();
      @(negedge clk);
    end
    if (!last) begin
      check("in_ready_after_chunk", in_ready, 1);
      check("running_sum", out_sum, acc_view(m_total));
      check("running_chunks", out_chunks, sat255(m_count));
    end else begin
      check("in_ready_in_output", in_ready, 0);
    end
  endtask

  // Monitor: pops the expected result when out_valid appears, checks latency and
  // stability while held, and drives out_ready with random back-pressure.
  initial begin : monitor
    exp_t cur;
    int   seen = 0;
    bit   prev_acc = 0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_have  = 0;
        prev_acc  = 0;
        out_ready = 1'b0;
      end else begin
        if (prev_acc) begin
          check("post_accept_valid", out_valid, 0);
          check("post_accept_sum", out_sum, 0);
          check("post_accept_chunks", out_chunks, 0);
          check("post_accept_ovf", out_overflow, 0);
          check("post_accept_busy", busy, 0);
          prev_acc = 0;
        end
        if (out_valid) begin
          if (!mon_have) begin
            if (exp_q.size() == 0) begin
              check("unexpected_out_valid", 1, 0);
              cur = '{longint'(out_sum), longint'(out_chunks), out_overflow, cyc, 0};
            end else begin
              cur = exp_q.pop_front();
              check("out_sum", out_sum, cur.sum);
              check("out_chunks", out_chunks, cur.chunks);
              check("out_overflow", out_overflow, cur.ovf);
              check("out_latency_cycle", cyc, cur.due);
            end
            mon_have = 1;
            seen = 0;
          end else begin
            check("hold_sum", out_sum, cur.sum);
            check("hold_chunks", out_chunks, cur.chunks);
            check("hold_ovf", out_overflow, cur.ovf);
          end
          check("in_ready_while_output", in_ready, 0);
          seen++;
          out_ready = (seen > cur.hold) && ($urandom_range(0, 2) != 0);
          if (out_ready) begin
            mon_have = 0;
            prev_acc = 1;
          end
        end else begin
          out_ready = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  int unsigned req33[8] = '{8, 14, 18, 20, 20, 18, 14, 8};

  initial begin : stimulus
    logic [DW*VS-1:0] v;
    int               waited = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_vector = '0;
    repeat (2) @(negedge clk);
    check("reset_sum", out_sum, 0);
    check("reset_chunks", out_chunks, 0);
    check("reset_ovf", out_overflow, 0);
    check("reset_busy", busy, 0);
    check("reset_out_valid", out_valid, 0);
    rst = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 1);

    // Known dot product: sum 120.
    for (int i = 0; i < VS; i++) v[i*DW +: DW] = DW'(req33[i]);
    send(v, 1'b1, 1'b0, -1, 0);
    // Two chunks of ones: single result of 16 with two chunks.
    send(fill(1), 1'b0, 1'b0, -1, 0);
    send(fill(1), 1'b1, 1'b0, -1, 1);
    // Max products with five cycles of back-pressure.
    send(fill(65025), 1'b1, 1'b0, -1, 5);
    // Reset in the fourth REDUCE cycle, then a clean all-ones dot product.
    send(fill(65025), 1'b1, 1'b0, 3, 0);
    send(fill(1), 1'b1, 1'b0, -1, 0);
    // in_valid held with changing data while busy.
    send(fill(3), 1'b1, 1'b1, -1, 2);
    // Several max chunks drive the 20-bit accumulator past its range.
    for (int c = 0; c < 3; c++) send(fill(65025), c == 2, 1'b0, -1, 0);

    // Random dot products of 1..4 chunks with occasional junk holds and resets.
    for (int d = 0; d < 30; d++) begin
      int n = $urandom_range(1, 4);
      for (int c = 0; c < n; c++) begin
        send(rand_vec(), c == n - 1, $urandom_range(0, 3) == 0,
             ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, VS - 1)) : -1,
             $urandom_range(0, 3));
      end
    end

    // Chunk counter saturation at 255.
    for (int c = 0; c < 260; c++) begin
      send(fill($urandom_range(0, 3)), c == 259, 1'b0, -1, 0);
    end

    while ((exp_q.size() != 0 || mon_have) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("drain_pending", exp_q.size() + int'(mon_have), 0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
    $finish;
  end

endmodule
